// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative FIPS-197 AES encryptor (Nk = 4/6/8), one round per clock, round keys expanded combinationally.
// Defining AES_ENC_ITER_ABORT_EN adds an abort input that cancels the in-flight block.
module aes_enc_iter #(
    parameter int Nk = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [32*Nk-1:0]  key,
    input  logic              load,
    input  logic [127:0]      pt,
`ifdef AES_ENC_ITER_ABORT_EN
    input  logic              abort,
`endif
    output logic              ready,
    output logic [127:0]      ct,
    output logic              valid
);
    localparam int Nr = Nk + 6;
    localparam int NW = 4 * (Nr + 1);
    localparam int RKW = 128 * (Nr + 1);
    localparam logic [79:0] RCON = 80'h01020408102040801b36;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, RUN} st_t;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // All round keys packed MSB-first: round key 0 occupies the top 128 bits.
    function automatic logic [RKW-1:0] expand(input logic [32*Nk-1:0] k);
        logic [31:0] w [NW];
        logic [31:0] t;
        logic [RKW-1:0] r;
        r = '0;
        for (int i = 0; i < NW; i++) begin
            if (i < Nk) begin
                w[i] = k[32*(Nk-i)-1 -: 32];
            end else begin
                t = w[i-1];
                if (i % Nk == 0)
                    t = sub_word({t[23:0], t[31:24]}) ^ {RCON[87-8*(i/Nk) -: 8], 24'h0};
                else if (Nk > 6 && i % Nk == 4)
                    t = sub_word(t);
                w[i] = w[i-Nk] ^ t;
            end
            r[RKW-1-32*i -: 32] = w[i];
        end
        return r;
    endfunction

    // Byte b of the state is row b%4, column b/4.
    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk, input logic fin);
        logic [7:0] a [16];
        logic [7:0] m [16];
        logic [127:0] r;
        for (int b = 0; b < 16; b++)
            a[b] = sb(s[127 - 8*(4*((b/4 + b%4) % 4) + b%4) -: 8]);
        for (int c = 0; c < 4; c++) begin
            m[4*c]   = xt(a[4*c]) ^ xt(a[4*c+1]) ^ a[4*c+1] ^ a[4*c+2] ^ a[4*c+3];
            m[4*c+1] = a[4*c] ^ xt(a[4*c+1]) ^ xt(a[4*c+2]) ^ a[4*c+2] ^ a[4*c+3];
            m[4*c+2] = a[4*c] ^ a[4*c+1] ^ xt(a[4*c+2]) ^ xt(a[4*c+3]) ^ a[4*c+3];
            m[4*c+3] = xt(a[4*c]) ^ a[4*c] ^ a[4*c+1] ^ a[4*c+2] ^ xt(a[4*c+3]);
        end
        for (int b = 0; b < 16; b++)
            r[127 - 8*b -: 8] = fin ? a[b] : m[b];
        return r ^ rk;
    endfunction

    st_t st, st_nx;
    logic [3:0] cnt;
    logic [127:0] s;
    logic [RKW-1:0] rk_all;
    logic [127:0] rnd;
    logic acc, last, stop;

`ifdef AES_ENC_ITER_ABORT_EN
    assign stop = abort;
`else
    assign stop = 1'b0;
`endif

    assign rk_all = expand(key);
    assign rnd = enc_round(s, rk_all[RKW-1-128*int'(cnt) -: 128], last);

    // The final-round cycle also accepts, so held loads stream one block per Nr cycles.
    always_comb begin
        last = st == RUN && cnt == 4'(Nr);
        ready = st == IDLE || last;
        acc = load && ready && !stop;
        st_nx = stop ? IDLE : acc ? RUN : last ? IDLE : st;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else st <= st_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            s <= '0;
            ct <= '0;
            valid <= 1'b0;
        end else begin
            valid <= last && !stop;
            if (last && !stop) ct <= rnd;
            if (acc) begin
                s <= pt ^ rk_all[RKW-1 -: 128];
                cnt <= 4'd1;
            end else if (stop || last) begin
                cnt <= '0;
            end else if (st == RUN) begin
                s <= rnd;
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_aes_enc_iter.sv
// tb_aes_enc_iter: scoreboard bench for Nk=4/6/8 instances against a byte-matrix AES reference model.
// Exercises abort when AES_ENC_ITER_ABORT_EN is defined.
module tb_aes_enc_iter;
    localparam int NK [3] = '{4, 6, 8};

    typedef struct {
        logic [127:0] ct;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [255:0] key [3];
    logic load [3];
    logic ab [3];
    logic [127:0] pt [3];
    logic ready [3];
    logic [127:0] ct [3];
    logic valid [3];

    logic [7:0] sbox_m [256];
    exp_t sb_q [3][$];
    exp_t e_new, e_got;
    int m_left [3];
    logic [127:0] hold [3];
    logic kat_en [3];
    logic [127:0] kat_ct [3];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aes_enc_iter #(.Nk(4)) u4 (.clk(clk), .rst_n(rst_n), .key(key[0][255:128]), .load(load[0]), .pt(pt[0]),
`ifdef AES_ENC_ITER_ABORT_EN
        .abort(ab[0]),
`endif
        .ready(ready[0]), .ct(ct[0]), .valid(valid[0]));
    aes_enc_iter #(.Nk(6)) u6 (.clk(clk), .rst_n(rst_n), .key(key[1][255:64]), .load(load[1]), .pt(pt[1]),
`ifdef AES_ENC_ITER_ABORT_EN
        .abort(ab[1]),
`endif
        .ready(ready[1]), .ct(ct[1]), .valid(valid[1]));
    aes_enc_iter #(.Nk(8)) u8 (.clk(clk), .rst_n(rst_n), .key(key[2]), .load(load[2]), .pt(pt[2]),
`ifdef AES_ENC_ITER_ABORT_EN
        .abort(ab[2]),
`endif
        .ready(ready[2]), .ct(ct[2]), .valid(valid[2]));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b};
        return t[15-n -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [255:0] k, input int nk, input logic [127:0] p);
        logic [31:0] w [60];
        logic [31:0] x;
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] rc = 8'h01;
        logic [127:0] o;
        int nr = nk + 6;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = k[255-32*i -: 32];
            end else begin
                x = w[i-1];
                if (i % nk == 0) begin
                    x = subw({x[23:0], x[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    x = subw(x);
                end
                w[i] = w[i-nk] ^ x;
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = p[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int n = 1; n <= nr; n++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_m[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    s[r][c] = (n < nr) ? gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c] : t[r][c];
                    s[r][c] ^= w[4*n+c][31-8*r -: 8];
                end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    // Protocol model: predicts accepts from its own busy count and queues the expected result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                m_left[d] = 0;
                sb_q[d].delete();
            end
        end else begin
            cyc++;
            for (int d = 0; d < 3; d++) begin
                if (ab[d]) begin
                    m_left[d] = 0;
                    if (sb_q[d].size() > 0 && sb_q[d][$].due >= cyc) void'(sb_q[d].pop_back());
                end else if (load[d] && m_left[d] <= 1) begin
                    e_new.ct = kat_en[d] ? kat_ct[d] : aes_ref(key[d], NK[d], pt[d]);
                    e_new.due = cyc + NK[d] + 6;
                    sb_q[d].push_back(e_new);
                    m_left[d] = NK[d] + 6;
                end else if (m_left[d] > 0) begin
                    m_left[d]--;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                hold[d] = '0;
                n_cmp++;
                if (ct[d] !== '0 || valid[d] !== 1'b0 || ready[d] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL reset nk=%0d: ct=%h valid=%b ready=%b, want ct=0 valid=0 ready=1", NK[d], ct[d], valid[d], ready[d]);
                end
            end else begin
                n_cmp++;
                if (ready[d] !== (m_left[d] <= 1)) begin
                    n_bad++;
                    $display("FAIL ready nk=%0d cyc=%0d: got %b want %b", NK[d], cyc, ready[d], m_left[d] <= 1);
                end
                if (valid[d] === 1'b1) begin
                    n_cmp++;
                    if (sb_q[d].size() == 0) begin
                        n_bad++;
                        $display("FAIL spurious_valid nk=%0d cyc=%0d: got valid=1 want none", NK[d], cyc);
                    end else begin
                        e_got = sb_q[d].pop_front();
                        if (e_got.due != cyc || ct[d] !== e_got.ct) begin
                            n_bad++;
                            $display("FAIL result nk=%0d: got ct=%h at cyc %0d want ct=%h at cyc %0d", NK[d], ct[d], cyc, e_got.ct, e_got.due);
                        end
                        hold[d] = e_got.ct;
                    end
                end else begin
                    n_cmp++;
                    if (ct[d] !== hold[d]) begin
                        n_bad++;
                        $display("FAIL ct_hold nk=%0d cyc=%0d: got %h want %h", NK[d], cyc, ct[d], hold[d]);
                    end
                    if (sb_q[d].size() > 0 && sb_q[d][0].due <= cyc) begin
                        n_bad++;
                        $display("FAIL missing_valid nk=%0d cyc=%0d: got valid=%b want ct=%h", NK[d], cyc, valid[d], sb_q[d][0].ct);
                        void'(sb_q[d].pop_front());
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_kat_keys();
        key[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        key[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        key[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    endtask

    initial begin
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int d = 0; d < 3; d++) begin
            load[d] = 1'b0;
            ab[d] = 1'b0;
            pt[d] = '0;
            kat_en[d] = 1'b0;
        end
        kat_ct[0] = 128'h3925841d02dc09fbdc118597196a0b32;
        kat_ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        kat_ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
        set_kat_keys();
        #2 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        // Known-answer vectors on all three key sizes at once.
        pt[0] = 128'h3243f6a8885a308d313198a2e0370734;
        pt[1] = 128'h00112233445566778899aabbccddeeff;
        pt[2] = 128'h00112233445566778899aabbccddeeff;
        for (int d = 0; d < 3; d++) begin
            kat_en[d] = 1'b1;
            load[d] = 1'b1;
        end
        tick(1);
        for (int d = 0; d < 3; d++) begin
            kat_en[d] = 1'b0;
            load[d] = 1'b0;
        end
        tick(20);
        // Load held high with fresh random plaintext every cycle.
        for (int d = 0; d < 3; d++)
            for (int j = 0; j < 8; j++)
                key[d][255-32*j -: 32] = $urandom;
        for (int n = 0; n < 10000; n++) begin
            for (int d = 0; d < 3; d++) begin
                load[d] = 1'b1;
                pt[d] = {$urandom, $urandom, $urandom, $urandom};
            end
            tick(1);
        end
        for (int d = 0; d < 3; d++) load[d] = 1'b0;
        tick(20);
        // Reset in round 5 of an Nk=4 block, then the FIPS vector again.
        set_kat_keys();
        pt[0] = {$urandom, $urandom, $urandom, $urandom};
        load[0] = 1'b1;
        tick(1);
        load[0] = 1'b0;
        tick(4);
        #2 rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        pt[0] = 128'h3243f6a8885a308d313198a2e0370734;
        kat_en[0] = 1'b1;
        load[0] = 1'b1;
        tick(1);
        kat_en[0] = 1'b0;
        load[0] = 1'b0;
        tick(15);
`ifdef AES_ENC_ITER_ABORT_EN
        pt[0] = {$urandom, $urandom, $urandom, $urandom};
        load[0] = 1'b1;
        tick(1);
        load[0] = 1'b0;
        tick(2);
        ab[0] = 1'b1;
        tick(1);
        ab[0] = 1'b0;
        tick(2);
        ab[0] = 1'b1;
        load[0] = 1'b1;
        tick(1);
        ab[0] = 1'b0;
        load[0] = 1'b0;
        tick(15);
        pt[0] = {$urandom, $urandom, $urandom, $urandom};
        load[0] = 1'b1;
        tick(1);
        load[0] = 1'b0;
        tick(15);
`endif
        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_enc_iter.md
AES_ENC_ITER -- requirements
Module: aes_enc_iter

Interface
REQ-001 The block SHALL have parameter Nk, default 4, meaning key length in 32-bit words; legal values 4, 6 and 8; round count Nr = Nk+6.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port key, input, 32*Nk bits: cipher key, byte 0 in MSBs; held stable by the user for the whole operation.
REQ-005 The block SHALL have port load, input, 1 bit: start request; sampled only while ready=1.
REQ-006 The block SHALL have port pt, input, 128 bits: plaintext, byte 0 in [127:120]; sampled with load.
REQ-007 The block SHALL have port ready, output, 1 bit: block accepts load this cycle.
REQ-008 The block SHALL have port ct, output, 128 bits: ciphertext, byte 0 in [127:120].
REQ-009 The block SHALL have port valid, output, 1 bit: one-cycle pulse marking a new ct.

Function
REQ-010 The block SHALL implement FIPS-197 AES encryption, one round per clock (iterative, not pipelined).
REQ-011 The block SHALL derive round keys 0..Nr combinationally from key with the FIPS-197 expansion for the configured Nk; no key-load handshake.
REQ-012 The block SHALL use FSM states IDLE and RUN; IDLE->RUN on load&ready; RUN->IDLE after round Nr unless a new load is accepted in that same cycle.
REQ-013 On the accepting edge the block SHALL capture state = pt XOR roundkey0 and set the round counter to 1.
REQ-014 In RUN the block SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey(r) per edge for r=1..Nr-1, and omit MixColumns for r=Nr.
REQ-015 The block SHALL update ct and pulse valid high for exactly one cycle, beginning Nr cycles after the accepting edge.
REQ-016 The block SHALL hold ct unchanged between valid pulses.
REQ-017 The block SHALL drive ready=1 in IDLE and during the valid cycle, and ready=0 otherwise in RUN.
REQ-018 A load with ready=0 SHALL be ignored without affecting the in-flight block.
REQ-019 A load during the valid cycle SHALL be accepted, giving back-to-back throughput of one block per Nr cycles.
REQ-020 The round counter SHALL count 1..Nr and SHALL never wrap past Nr.

Reset
REQ-021 While rst_n=0 the block SHALL force FSM=IDLE, round counter=0, internal state=0, ct=0, valid=0 and ready=1, asynchronously.
REQ-022 Reset asserted mid-operation SHALL abandon the block with no valid pulse; the first load after deassertion SHALL work normally.

Configuration
REQ-023 With macro AES_ENC_ITER_ABORT_EN defined, the block SHALL add input port abort (1 bit); abort=1 at an edge SHALL return the FSM to IDLE, suppress valid, hold ct, and take priority over load.
REQ-024 Without AES_ENC_ITER_ABORT_EN, the port and logic SHALL be absent and behaviour SHALL be per REQ-010..REQ-020.

Verification
REQ-025 The bench SHALL check Nk=4: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32, valid exactly 10 cycles after load.
REQ-026 The bench SHALL check Nk=6: key 000102...17, pt 00112233445566778899aabbccddeeff -> ct dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles; and Nk=8: key 000102...1f, same pt -> ct 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
REQ-027 The bench SHALL hold load=1 continuously for 1000 random pt and check vs aes_encrypt DPI model: exactly one accept per Nr cycles, in-order results, ignored loads causing no extra valid.
REQ-028 The bench SHALL pulse rst_n=0 at round 5 -> ct=0, valid=0, ready=1 immediately; the next Nk=4 FIPS vector then passes.
REQ-029 With AES_ENC_ITER_ABORT_EN, the bench SHALL assert abort at round 3 -> no valid, ct retains previous value, ready=1 next cycle; abort and load together -> no accept.
